// File: rtl/mic_capture_sched_pkg.sv
// Shared types and CSR layout for the microphone capture scheduler.
package mic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam logic [2:0] CSR_BUF_A  = 3'd2;
    localparam logic [2:0] CSR_BUF_B  = 3'd3;
    localparam logic [2:0] CSR_COUNT  = 3'd4;
    localparam logic [2:0] CSR_FILL   = 3'd5;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_CONTINUOUS = 1;
    localparam int CTRL_IRQ_EN     = 2;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_ACTIVE_BUF = 1;
    localparam int STAT_A_FULL     = 2;
    localparam int STAT_B_FULL     = 3;
    localparam int STAT_OVERRUN    = 4;
    localparam int STAT_TIMEOUT    = 5;

endpackage

// File: rtl/mic_capture_sched_if.sv
// CSR bus and DMA handshake bundle between the HPS-side master and the scheduler.
interface mic_capture_sched_if;
    logic [2:0]  AS_ADDR;
    logic        AS_READ;
    logic        AS_WRITE;
    logic [31:0] AS_WRITEDATA;
    logic [31:0] AS_READDATA;
    logic        DMA_START;
    logic [31:0] DMA_ADDR;
    logic [31:0] DMA_COUNT;
    logic        DMA_FINISHED;
    logic        IRQ;

    modport master (
        output AS_ADDR, AS_READ, AS_WRITE, AS_WRITEDATA, DMA_FINISHED,
        input  AS_READDATA, DMA_START, DMA_ADDR, DMA_COUNT, IRQ
    );

    modport slave (
        input  AS_ADDR, AS_READ, AS_WRITE, AS_WRITEDATA, DMA_FINISHED,
        output AS_READDATA, DMA_START, DMA_ADDR, DMA_COUNT, IRQ
    );
endinterface

// File: rtl/mic_capture_sched_csr.sv
// CSR storage and decode: control, sticky status with W1C, buffer setup, fill counter, IRQ.
module mic_sched_csr
    import mic_sched_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        busy,
    input  logic        done,
    input  logic        tmo,
    input  logic        clr_enable,
    output logic        enable,
    output logic        continuous,
    output logic        active_buf,
    output logic [31:0] buf_a,
    output logic [31:0] buf_b,
    output logic [31:0] count
);

    logic        irq_en;
    logic        a_full, b_full, overrun, timeout;
    logic [31:0] fill_cnt;
    logic [31:0] rd_mux;
    logic        wr_ctrl, wr_status;
    logic        set_a, set_b, set_ov;

    assign wr_ctrl   = wr && (addr == CSR_CTRL);
    assign wr_status = wr && (addr == CSR_STATUS);
    assign set_a     = done && !active_buf;
    assign set_b     = done && active_buf;
    assign set_ov    = done && (active_buf ? b_full : a_full);

    always_comb begin
        rd_mux = '0;
        case (addr)
            CSR_CTRL:   rd_mux = {29'd0, irq_en, continuous, enable};
            CSR_STATUS: rd_mux = {26'd0, timeout, overrun, b_full, a_full, active_buf, busy};
            CSR_BUF_A:  rd_mux = buf_a;
            CSR_BUF_B:  rd_mux = buf_b;
            CSR_COUNT:  rd_mux = count;
            CSR_FILL:   rd_mux = fill_cnt;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable     <= 1'b0;
            continuous <= 1'b0;
            irq_en     <= 1'b0;
            a_full     <= 1'b0;
            b_full     <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            active_buf <= 1'b0;
            buf_a      <= '0;
            buf_b      <= '0;
            count      <= '0;
            fill_cnt   <= '0;
            rdata      <= '0;
            irq        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable     <= wdata[CTRL_ENABLE];
                continuous <= wdata[CTRL_CONTINUOUS];
                irq_en     <= wdata[CTRL_IRQ_EN];
            end
            // Hardware clear of ENABLE overrides a software write in the same cycle.
            if (clr_enable || tmo)
                enable <= 1'b0;

            // Hardware set beats a simultaneous write-1-to-clear.
            a_full  <= (a_full  & ~(wr_status & wdata[STAT_A_FULL]))  | set_a;
            b_full  <= (b_full  & ~(wr_status & wdata[STAT_B_FULL]))  | set_b;
            overrun <= (overrun & ~(wr_status & wdata[STAT_OVERRUN])) | set_ov;
            timeout <= (timeout & ~(wr_status & wdata[STAT_TIMEOUT])) | tmo;

            if (done) begin
                active_buf <= ~active_buf;
                fill_cnt   <= fill_cnt + 32'd1;
            end

            if (wr && addr == CSR_BUF_A) buf_a <= {wdata[31:2], 2'b00};
            if (wr && addr == CSR_BUF_B) buf_b <= {wdata[31:2], 2'b00};
            if (wr && addr == CSR_COUNT) count <= wdata;

            if (rd) rdata <= rd_mux;
            irq <= irq_en & (a_full | b_full | overrun | timeout);
        end
    end

endmodule

// File: rtl/mic_capture_sched.sv
// Ping-pong microphone capture scheduler: sequences DMA fills into buffers A/B with a RUN watchdog.
module mic_capture_sched
    import mic_sched_pkg::*;
#(
    parameter int DONE_TIMEOUT = 1048576
) (
    input logic CLK,
    input logic RESET,
    mic_capture_sched_if.slave bus
);

    localparam logic [31:0] WDOG_LAST = 32'(DONE_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        fin_q;
    logic        fin_rise;
    logic [31:0] wdog_q;
    logic [31:0] dma_addr_q, dma_count_q;
    logic        done, tmo, clr_enable;
    logic        enable, continuous, active_buf;
    logic [31:0] buf_a, buf_b, count;
    logic        busy;

    assign fin_rise = bus.DMA_FINISHED && !fin_q;
    assign busy     = (state_q != IDLE);

    mic_sched_csr u_csr (
        .CLK        (CLK),
        .RESET      (RESET),
        .addr       (bus.AS_ADDR),
        .rd         (bus.AS_READ),
        .wr         (bus.AS_WRITE),
        .wdata      (bus.AS_WRITEDATA),
        .rdata      (bus.AS_READDATA),
        .irq        (bus.IRQ),
        .busy       (busy),
        .done       (done),
        .tmo        (tmo),
        .clr_enable (clr_enable),
        .enable     (enable),
        .continuous (continuous),
        .active_buf (active_buf),
        .buf_a      (buf_a),
        .buf_b      (buf_b),
        .count      (count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            fin_q       <= 1'b0;
            wdog_q      <= '0;
            dma_addr_q  <= '0;
            dma_count_q <= '0;
        end else begin
            state_q <= state_d;
            fin_q   <= bus.DMA_FINISHED;
            if (state_q == ARM) begin
                wdog_q      <= '0;
                dma_addr_q  <= active_buf ? buf_b : buf_a;
                dma_count_q <= count;
            end else if (state_q == RUN) begin
                wdog_q <= wdog_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        tmo        = 1'b0;
        clr_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && count != 32'd0)
                    state_d = ARM;
            end
            ARM: state_d = RUN;
            RUN: begin
                // A real completion in the final watchdog cycle still counts as a fill.
                if (fin_rise) begin
                    done    = 1'b1;
                    state_d = RELEASE;
                end else if (wdog_q == WDOG_LAST) begin
                    tmo     = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.DMA_FINISHED) begin
                    if (enable && continuous) begin
                        state_d = ARM;
                    end else begin
                        clr_enable = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.DMA_START = (state_q == RUN);
    assign bus.DMA_ADDR  = dma_addr_q;
    assign bus.DMA_COUNT = dma_count_q;

endmodule
